debounce_edge_n: RTL and testbench



---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_chan.sv | 58 +++++
 rtl/debounce_edge_n.sv | 65 ++++++
 tb/tb_debounce_edge_n.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debounce_pkg
// Brief   : Shared constants for the board-input debouncer (cycle counts,
//           channel indices, default polarity mask).
// Revision: 1.0 - initial release
// ============================================================================
package debounce_pkg;

  localparam int DB_DEFAULT_CYCLES_50MHZ = 500000;
  localparam int DB_SIM_CYCLES           = 8;
  localparam int DB_DEFAULT_N_CH         = 22;

  localparam int CH_BTND   = 0;
  localparam int CH_BTNR   = 1;
  localparam int CH_BTNU   = 2;
  localparam int CH_BTNL   = 3;
  localparam int CH_BTNC   = 4;
  localparam int CH_RESETN = 5;
  localparam int CH_SW0    = 6;

  // CPU_RESETN is the only active-low pin on the board.
  localparam logic [DB_DEFAULT_N_CH-1:0] DB_DEFAULT_INV_MASK =
    DB_DEFAULT_N_CH'(1) << CH_RESETN;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module  : debounce_chan
// Brief   : One debounce channel: stability counter, accepted level and
//           registered rise/fall event pulses.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int DB_CYCLES = DB_DEFAULT_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic i_s,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DB_CYCLES - 1);

  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  // Any agreeing sample restarts the count, so only an unbroken run of
  // DB_CYCLES differing samples changes the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db   <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_s == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == c_last_cnt) begin
        r_db   <= i_s;
        r_cnt  <= '0;
        r_rise <= i_s;
        r_fall <= ~i_s;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_edge_n.sv
`default_nettype none
// ============================================================================
// Module  : debounce_edge_n
// Brief   : N-channel board-input debouncer with 2-FF synchronisers,
//           per-channel polarity correction and rise/fall event pulses.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_edge_n
  import debounce_pkg::*;
#(
  parameter int              N_CH      = DB_DEFAULT_N_CH,
  parameter int              CNT_W     = 20,
  parameter int              DB_CYCLES = DB_DEFAULT_CYCLES_50MHZ,
  parameter logic [N_CH-1:0] INV_MASK  = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in_raw,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_change
);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] w_s;
  logic [N_CH-1:0] w_db;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;

  // Resetting to INV_MASK makes an idle active-low pin read inactive at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= INV_MASK;
      r_sync2 <= INV_MASK;
    end else begin
      r_sync1 <= in_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ INV_MASK;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    debounce_chan #(
      .CNT_W     (CNT_W),
      .DB_CYCLES (DB_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (reset),
      .i_s    (w_s[g]),
      .o_db   (w_db[g]),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

  assign db_out     = w_db;
  assign rise_pulse = w_rise;
  assign fall_pulse = w_fall;
  assign any_change = |(w_rise | w_fall);

endmodule : debounce_edge_n
`default_nettype wire

// File: tb/tb_debounce_edge_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_debounce_edge_n
// Brief   : Directed self-checking bench for debounce_edge_n.
// Revision: 1.0 - initial release
// ============================================================================
module tb_debounce_edge_n;
  import debounce_pkg::*;

  localparam int NCH = 22;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] in_raw;
  logic [NCH-1:0] db_out, rise_pulse, fall_pulse;
  logic           any_change;

  logic [1:0]     raw1;
  logic [1:0]     db1, rise1, fall1;
  logic           any1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  debounce_edge_n #(
    .N_CH      (NCH),
    .CNT_W     (20),
    .DB_CYCLES (DB_SIM_CYCLES),
    .INV_MASK  (DB_DEFAULT_INV_MASK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_raw     (in_raw),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  // Minimum-length variant: a level is accepted on its first differing sample.
  debounce_edge_n #(
    .N_CH      (2),
    .CNT_W     (4),
    .DB_CYCLES (1),
    .INV_MASK  (2'b00)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_raw     (raw1),
    .db_out     (db1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .any_change (any1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [NCH-1:0] exp_db);
    chk({tag, ".db"}, db_out, exp_db);
    chk({tag, ".pulse"}, rise_pulse | fall_pulse, '0);
    chk({tag, ".any"}, NCH'(any_change), '0);
  endtask

  // Input already driven before the first sampling edge; acceptance lands on
  // the tenth edge (2 sync edges + 8 counting edges) and the pulse lasts 1 cycle.
  task automatic expect_accept(input string tag, input logic [NCH-1:0] db_before,
                               input logic [NCH-1:0] db_after,
                               input logic [NCH-1:0] exp_rise,
                               input logic [NCH-1:0] exp_fall);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_quiet({tag, ".wait"}, db_before);
    end
    tick();
    chk({tag, ".db_acc"}, db_out, db_after);
    chk({tag, ".rise"}, rise_pulse, exp_rise);
    chk({tag, ".fall"}, fall_pulse, exp_fall);
    chk({tag, ".any_hi"}, NCH'(any_change), NCH'(1));
    tick();
    chk_quiet({tag, ".after"}, db_after);
  endtask

  initial begin
    reset  = 1'b1;
    in_raw = 22'h000020;
    raw1   = 2'b00;
    tick(); tick(); tick();
    chk_quiet("rst_hold", '0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_quiet("idle", '0);
    end

    // Clean rise then clean fall on BTNL.
    in_raw[3] = 1'b1;
    expect_accept("rise3", 22'h0, 22'h8, 22'h8, 22'h0);
    in_raw[3] = 1'b0;
    expect_accept("fall3", 22'h8, 22'h0, 22'h0, 22'h8);

    // Bounce: 3-cycle segments never reach the 8-sample threshold.
    for (int seg = 0; seg < 8; seg++) begin
      in_raw[3] = (seg % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk_quiet("bounce", 22'h0);
      end
    end
    in_raw[3] = 1'b1;
    expect_accept("bounce_end", 22'h0, 22'h8, 22'h8, 22'h0);

    // 7-cycle glitch is one short of acceptance.
    in_raw[7] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_quiet("glitch7_hi", 22'h8);
    end
    in_raw[7] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_quiet("glitch7_lo", 22'h8);
    end

    // BTND rises and active-low CPU_RESETN is pressed together.
    in_raw[0] = 1'b1;
    in_raw[5] = 1'b0;
    expect_accept("simul", 22'h8, 22'h29, 22'h21, 22'h0);

    // Reset mid-count on SW3: partial count and all levels are discarded,
    // and every held-active input is re-accepted together.
    in_raw[9] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_quiet("pre_rst9", 22'h29);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_quiet("rst_mid", 22'h0);
    expect_accept("post_rst", 22'h0, 22'h229, 22'h229, 22'h0);

    // DB_CYCLES = 1 variant.
    raw1 = 2'b01;
    tick();
    chk("db1.e1", NCH'(db1), '0);
    tick();
    chk("db1.e2", NCH'(db1), '0);
    tick();
    chk("db1.acc", NCH'(db1), NCH'(1));
    chk("db1.rise", NCH'(rise1), NCH'(1));
    chk("db1.any", NCH'(any1), NCH'(1));
    tick();
    chk("db1.rise_off", NCH'({rise1, fall1}), '0);
    raw1 = 2'b00;
    tick(); tick(); tick();
    chk("db1.fall", NCH'({db1, fall1}), NCH'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_debounce_edge_n
`default_nettype wire
